// File: rtl/protectlib_sync_mux.sv
// protectlib_sync_mux
//
// Per-channel result multiplexer that arbitrates between a combinational
// result path and a clocked (one-stage pipelined) result path. Each channel
// keeps the latest value/tag of each kind and forwards whichever was tagged
// more recently, using wrap-around tag comparison. Updates are accepted
// only after a library hash has been presented and matched.
//
// Optional build macro: PROTECTLIB_STALE_FILTER_EN
//   defined   : updates whose tag is not newer than the stored tag of the
//               same kind are dropped and counted in stale_cnt (saturating).
//   undefined : every update in RUN is captured; stale_cnt is constant 0.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   hash_valid   hash_value presented this cycle
//   hash_value   library hash (32 bits)
//   combo_valid  per-channel combinational-result strobe
//   combo_data   NCH packed combinational results
//   combo_seq    tag shared by all combo strobes this cycle
//   seq_valid    per-channel clocked-result strobe
//   seq_data     NCH packed clocked results
//   seq_seq      tag shared by all seq strobes this cycle
//   out_data     NCH packed selected results (registered)
//   out_src      per channel: 1 = seq result selected, 0 = combo result
//   ready        hash matched, updates are being accepted
//   hash_err     hash mismatch seen; terminal until rst
//   stale_cnt    number of rejected stale updates
module protectlib_sync_mux #(
  parameter int          DATA_W = 32,
  parameter int          NCH    = 4,
  parameter int          SEQ_W  = 16,
  parameter logic [31:0] HASH   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hash_valid,
  input  logic [31:0]           hash_value,
  input  logic [NCH-1:0]        combo_valid,
  input  logic [NCH*DATA_W-1:0] combo_data,
  input  logic [SEQ_W-1:0]      combo_seq,
  input  logic [NCH-1:0]        seq_valid,
  input  logic [NCH*DATA_W-1:0] seq_data,
  input  logic [SEQ_W-1:0]      seq_seq,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        out_src,
  output logic                  ready,
  output logic                  hash_err,
  output logic [15:0]           stale_cnt
);

  typedef enum logic [1:0] {
    WAIT_HASH = 2'd0,
    RUN       = 2'd1,
    ERROR     = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   run;

  // A is newer than B when (A-B) mod 2^SEQ_W is nonzero and in the lower half.
  function automatic logic is_newer(input logic [SEQ_W-1:0] a,
                                    input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] d;
    d = a - b;
    return (d != '0) && !d[SEQ_W-1];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_HASH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    hash_err  = 1'b0;
    run       = 1'b0;
    case (state)
      WAIT_HASH: begin
        if (hash_valid) state_nxt = (hash_value == HASH) ? RUN : ERROR;
      end
      RUN: begin
        ready = 1'b1;
        run   = 1'b1;
      end
      ERROR: begin
        hash_err = 1'b1;
      end
      default: state_nxt = WAIT_HASH;
    endcase
  end

  // ---- stage p0: seq update pipeline register ----
  logic [NCH-1:0]        seq_vld_p0;
  logic [NCH*DATA_W-1:0] seq_data_p0;
  logic [SEQ_W-1:0]      seq_tag_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_vld_p0  <= '0;
      seq_data_p0 <= '0;
      seq_tag_p0  <= '0;
    end else begin
      seq_vld_p0 <= run ? seq_valid : '0;
      if (run && (seq_valid != '0)) begin
        seq_data_p0 <= seq_data;
        seq_tag_p0  <= seq_seq;
      end
    end
  end

  // ---- stage p1: per-channel storage of combo and seq value/tag ----
  logic [NCH*DATA_W-1:0] combo_data_p1;
  logic [NCH*DATA_W-1:0] seq_data_p1;
  logic [SEQ_W-1:0]      combo_tag_p1 [NCH];
  logic [SEQ_W-1:0]      seq_tag_p1   [NCH];
  logic [NCH-1:0]        combo_hit;
  logic [NCH-1:0]        combo_we;
  logic [NCH-1:0]        seq_we;

  always_comb begin
    combo_hit = '0;
    combo_we  = '0;
    seq_we    = '0;
    for (int i = 0; i < NCH; i++) begin
      combo_hit[i] = run && combo_valid[i];
`ifdef PROTECTLIB_STALE_FILTER_EN
      combo_we[i]  = combo_hit[i] && is_newer(combo_seq, combo_tag_p1[i]);
      seq_we[i]    = seq_vld_p0[i] && is_newer(seq_tag_p0, seq_tag_p1[i]);
`else
      combo_we[i]  = combo_hit[i];
      seq_we[i]    = seq_vld_p0[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combo_data_p1 <= '0;
      seq_data_p1   <= '0;
      for (int i = 0; i < NCH; i++) begin
        combo_tag_p1[i] <= '0;
        seq_tag_p1[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (combo_we[i]) begin
          combo_data_p1[i*DATA_W +: DATA_W] <= combo_data[i*DATA_W +: DATA_W];
          combo_tag_p1[i]                   <= combo_seq;
        end
        if (seq_we[i]) begin
          seq_data_p1[i*DATA_W +: DATA_W] <= seq_data_p0[i*DATA_W +: DATA_W];
          seq_tag_p1[i]                   <= seq_tag_p0;
        end
      end
    end
  end

  // ---- stage p2: registered selection; equal tags favour combo ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (is_newer(seq_tag_p1[i], combo_tag_p1[i])) begin
          out_data[i*DATA_W +: DATA_W] <= seq_data_p1[i*DATA_W +: DATA_W];
          out_src[i]                   <= 1'b1;
        end else begin
          out_data[i*DATA_W +: DATA_W] <= combo_data_p1[i*DATA_W +: DATA_W];
          out_src[i]                   <= 1'b0;
        end
      end
    end
  end

`ifdef PROTECTLIB_STALE_FILTER_EN
  // Up to 2*NCH (<= 32) drops per cycle, each counted individually.
  function automatic logic [15:0] sat_add(input logic [15:0] a,
                                          input logic [5:0]  b);
    logic [16:0] s;
    s = {1'b0, a} + {11'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [5:0] drop_num;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NCH; i++) begin
      drop_num = drop_num + 6'(combo_hit[i] & ~combo_we[i])
                          + 6'(seq_vld_p0[i] & ~seq_we[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stale_cnt <= '0;
    else     stale_cnt <= sat_add(stale_cnt, drop_num);
  end
`else
  assign stale_cnt = '0;
`endif

endmodule

// File: tb/tb_protectlib_sync_mux.sv
// Self-checking bench for protectlib_sync_mux: directed scenarios followed by
// randomized traffic, all compared every cycle against a cycle-level
// behavioural model of per-channel latest-value storage.
module tb_protectlib_sync_mux;
  localparam int          DATA_W = 32;
  localparam int          NCH    = 4;
  localparam int          SEQ_W  = 16;
  localparam logic [31:0] HASH   = 32'h4ACA_1E16;
  localparam int          VW     = NCH*DATA_W;
  localparam int          TMOD   = 1 << SEQ_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  hash_valid = 1'b0;
  logic [31:0]           hash_value = '0;
  logic [NCH-1:0]        combo_valid = '0;
  logic [VW-1:0]         combo_data = '0;
  logic [SEQ_W-1:0]      combo_seq = '0;
  logic [NCH-1:0]        seq_valid = '0;
  logic [VW-1:0]         seq_data = '0;
  logic [SEQ_W-1:0]      seq_seq = '0;
  logic [VW-1:0]         out_data;
  logic [NCH-1:0]        out_src;
  logic                  ready;
  logic                  hash_err;
  logic [15:0]           stale_cnt;

  protectlib_sync_mux #(.DATA_W(DATA_W), .NCH(NCH), .SEQ_W(SEQ_W), .HASH(HASH)) dut (
    .clk(clk), .rst(rst), .hash_valid(hash_valid), .hash_value(hash_value),
    .combo_valid(combo_valid), .combo_data(combo_data), .combo_seq(combo_seq),
    .seq_valid(seq_valid), .seq_data(seq_data), .seq_seq(seq_seq),
    .out_data(out_data), .out_src(out_src), .ready(ready),
    .hash_err(hash_err), .stale_cnt(stale_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: latest accepted value/tag of each kind per channel,
  // plus seq updates waiting out their one-cycle delay.
  logic [DATA_W-1:0] m_cdata [NCH];
  logic [DATA_W-1:0] m_sdata [NCH];
  int                m_ctag  [NCH];
  int                m_stag  [NCH];
  bit                p_vld   [NCH];
  logic [DATA_W-1:0] p_data  [NCH];
  int                p_tag;
  bit                m_run;
  bit                m_err;
  int                m_stale;
  logic [VW-1:0]     exp_data;
  logic [NCH-1:0]    exp_src;

  function automatic bit newer(int a, int b);
    int d;
    d = ((a - b) % TMOD + TMOD) % TMOD;
    return (d != 0) && (d < TMOD/2);
  endfunction

  function automatic bit accept(int t, int stored);
`ifdef PROTECTLIB_STALE_FILTER_EN
    return newer(t, stored);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cdata[i] = '0; m_sdata[i] = '0; m_ctag[i] = 0; m_stag[i] = 0;
      p_vld[i] = 1'b0; p_data[i] = '0;
    end
    p_tag = 0; m_run = 1'b0; m_err = 1'b0; m_stale = 0;
  endtask

  task automatic model_select();
    for (int i = 0; i < NCH; i++) begin
      exp_src[i] = newer(m_stag[i], m_ctag[i]);
      exp_data[i*DATA_W +: DATA_W] = exp_src[i] ? m_sdata[i] : m_cdata[i];
    end
  endtask

  task automatic model_edge();
    int drops;
    bit was_run;
    drops = 0;
    was_run = m_run;
    for (int i = 0; i < NCH; i++) begin
      if (p_vld[i]) begin
        if (accept(p_tag, m_stag[i])) begin m_sdata[i] = p_data[i]; m_stag[i] = p_tag; end
        else drops++;
      end
      if (was_run && combo_valid[i]) begin
        if (accept(int'(combo_seq), m_ctag[i])) begin
          m_cdata[i] = combo_data[i*DATA_W +: DATA_W]; m_ctag[i] = int'(combo_seq);
        end else drops++;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      p_vld[i]  = was_run && seq_valid[i];
      p_data[i] = seq_data[i*DATA_W +: DATA_W];
    end
    p_tag = int'(seq_seq);
    if (!m_run && !m_err && hash_valid) begin
      if (hash_value == HASH) m_run = 1'b1;
      else                    m_err = 1'b1;
    end
`ifdef PROTECTLIB_STALE_FILTER_EN
    m_stale = (m_stale + drops > 65535) ? 65535 : m_stale + drops;
`endif
  endtask

  // One clock: model predicts, DUT is sampled 1 time unit after the edge.
  task automatic step();
    model_select();
    @(posedge clk);
    model_edge();
    #1;
    check("out_data", out_data, exp_data);
    check("out_src", VW'(out_src), VW'(exp_src));
    check("ready", VW'(ready), VW'(m_run));
    check("hash_err", VW'(hash_err), VW'(m_err));
    check("stale_cnt", VW'(stale_cnt), VW'(m_stale));
    combo_valid = '0;
    seq_valid   = '0;
    hash_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_out_data", out_data, '0);
    check("rst_out_src", VW'(out_src), '0);
    check("rst_ready", VW'(ready), '0);
    check("rst_hash_err", VW'(hash_err), '0);
    check("rst_stale", VW'(stale_cnt), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    combo_valid = '0; seq_valid = '0; hash_valid = 1'b0;
  endtask

  task automatic enter_run();
    hash_valid = 1'b1;
    hash_value = HASH;
    step();
    check("ready_after_hash", VW'(ready), VW'(1'b1));
  endtask

  task automatic set_combo(int ch, logic [DATA_W-1:0] d, logic [SEQ_W-1:0] t);
    combo_valid[ch] = 1'b1;
    combo_data[ch*DATA_W +: DATA_W] = d;
    combo_seq = t;
  endtask

  task automatic set_seq(int ch, logic [DATA_W-1:0] d, logic [SEQ_W-1:0] t);
    seq_valid[ch] = 1'b1;
    seq_data[ch*DATA_W +: DATA_W] = d;
    seq_seq = t;
  endtask

  function automatic logic [VW-1:0] chan(int ch);
    return VW'(out_data[ch*DATA_W +: DATA_W]);
  endfunction

  logic [15:0] base;

  initial begin
    model_reset();
    #3;
    do_reset();

    // Hash mismatch: terminal error, strobes ignored
    hash_valid = 1'b1; hash_value = 32'h1;
    set_combo(0, 32'h1111, 16'd3);
    step();
    check("mismatch_hash_err", VW'(hash_err), VW'(1'b1));
    check("mismatch_ready", VW'(ready), '0);
    for (int k = 0; k < 3; k++) begin
      set_combo(1, 32'h2222, 16'(k + 1)); set_seq(1, 32'h3333, 16'(k + 2));
      hash_valid = 1'b1; hash_value = HASH;
      step();
    end
    check("error_ready_held", VW'(ready), '0);
    check("error_out_held", out_data, '0);

    // Hash match with simultaneous strobes: strobes dropped
    do_reset();
    hash_valid = 1'b1; hash_value = HASH;
    set_combo(0, 32'hDEAD, 16'd3);
    enter_run();
    step(); step();
    check("wait_hash_strobe_dropped", chan(0), '0);

    // Combo then seq latency on ch0
    do_reset();
    enter_run();
    set_combo(0, 32'hA5, 16'd5);
    step();
    set_seq(0, 32'h5A, 16'd6);
    step();
    check("lat_combo_data", chan(0), VW'(32'hA5));
    check("lat_combo_src", VW'(out_src[0]), '0);
    step();
    step();
    check("lat_seq_data", chan(0), VW'(32'h5A));
    check("lat_seq_src", VW'(out_src[0]), VW'(1'b1));

    // Wrap-around: combo tag 16'hFFFE then seq tag 1 -> seq newer
    do_reset();
    enter_run();
    set_combo(0, 32'h4, 16'h4000); step();
    set_combo(0, 32'h8, 16'h8000); step();
    set_combo(0, 32'hC, 16'hC000); step();
    set_combo(0, 32'h111, 16'hFFFE); step();
    set_seq(0, 32'h222, 16'h0001); step();
    step(); step();
    check("wrap_src", VW'(out_src[0]), VW'(1'b1));
    check("wrap_data", chan(0), VW'(32'h222));

    // Equal tags on ch2 in the same cycle -> combo wins
    set_combo(2, 32'hC0C0, 16'd9);
    set_seq(2, 32'h5E5E, 16'd9);
    step(); step(); step();
    check("equal_src", VW'(out_src[2]), '0);
    check("equal_data", chan(2), VW'(32'hC0C0));

    // Older combo tag on ch1
    do_reset();
    enter_run();
    set_combo(1, 32'h10, 16'd10); step();
    set_combo(1, 32'h7, 16'd7); step();
    step();
`ifdef PROTECTLIB_STALE_FILTER_EN
    check("stale_data", chan(1), VW'(32'h10));
    check("stale_cnt_val", VW'(stale_cnt), VW'(16'd1));
`else
    check("stale_data", chan(1), VW'(32'h7));
    check("stale_cnt_val", VW'(stale_cnt), '0);
`endif

    // Reset one cycle after a seq strobe: the value never appears
    do_reset();
    enter_run();
    set_seq(0, 32'hBEEF, 16'd1);
    step();
    do_reset();
    enter_run();
    step(); step(); step();
    check("inflight_discard", chan(0), '0);

    // Randomized traffic around the tag wrap point
    do_reset();
    enter_run();
    base = 16'hFFF0;
    for (int k = 0; k < 300; k++) begin
      combo_valid = NCH'($urandom);
      seq_valid   = NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        combo_data[i*DATA_W +: DATA_W] = $urandom;
        seq_data[i*DATA_W +: DATA_W]   = $urandom;
      end
      combo_seq  = base + 16'($urandom_range(0, 6)) - 16'd3;
      seq_seq    = base + 16'($urandom_range(0, 6)) - 16'd3;
      hash_valid = 1'($urandom);
      hash_value = $urandom;
      base       = base + 16'($urandom_range(0, 2));
      step();
      if (k == 150) begin
        do_reset();
        enter_run();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/protectlib_sync_mux.md
PROTECTLIB_SYNC_MUX -- requirements
Module: protectlib_sync_mux

Interface
REQ-001 Parameter DATA_W, 32, width of each channel result.
REQ-002 Parameter NCH, 4, number of independent output channels (1..16).
REQ-003 Parameter SEQ_W, 16, width of update sequence tags.
REQ-004 Parameter HASH, 32'h0, expected library hash.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 hash_valid / hash_value  in  1 / 32  library hash presentation.
REQ-008 combo_valid  in  NCH  per-channel combinational-update strobe.
REQ-009 combo_data / combo_seq  in  NCH*DATA_W / SEQ_W  combo results, shared tag.
REQ-010 seq_valid  in  NCH  per-channel clock-edge-update strobe.
REQ-011 seq_data / seq_seq  in  NCH*DATA_W / SEQ_W  seq results, shared tag.
REQ-012 out_data / out_src  out  NCH*DATA_W / NCH  selected result; src 1 = seq, 0 = combo.
REQ-013 ready / hash_err  out  1 / 1  run state reached / hash mismatch.
REQ-014 stale_cnt  out  16  count of rejected stale updates.

Function
REQ-015 FSM states WAIT_HASH, RUN, ERROR; reset enters WAIT_HASH.
REQ-016 WAIT_HASH: hash_valid with hash_value==HASH -> RUN next cycle; mismatch -> ERROR.
REQ-017 ERROR is terminal until rst; hash_err=1, ready=0, updates ignored, outputs hold.
REQ-018 RUN: ready=1; update strobes are ignored in any other state.
REQ-019 Per channel, storage holds combo value+tag and seq value+tag, all reset to 0.
REQ-020 Combo update captured at the edge where combo_valid[i]=1; tag stored with it.
REQ-021 Seq update captured one cycle after seq_valid[i]=1 (data and tag pipelined one stage).
REQ-022 Tag comparison is wrap-around: A newer than B iff (A-B) mod 2^SEQ_W is nonzero and below 2^(SEQ_W-1).
REQ-023 Selection: out_src[i]=1 iff stored seq tag newer than stored combo tag; equal tags select combo.
REQ-024 out_data/out_src registered; reflect storage one cycle after capture.
REQ-025 Combo latency strobe->out 2 cycles; seq latency strobe->out 3 cycles.
REQ-026 Simultaneous combo and seq strobes on one channel: both captured; REQ-023 decides.
REQ-027 Simultaneous hash_valid and update strobes in WAIT_HASH: strobes dropped.
REQ-028 Channels are independent; a strobe on channel i never alters channel j.

Reset
REQ-029 rst asserts asynchronously: out_data=0, out_src=0, ready=0, hash_err=0, stale_cnt=0, all tags 0, pipeline stage cleared, state WAIT_HASH.
REQ-030 rst mid-operation discards any in-flight seq update; rst deassertion takes effect at the next rising clk.

Configuration
REQ-031 Macro PROTECTLIB_STALE_FILTER_EN.
REQ-032 Defined: an update whose tag is not newer than the stored tag of the same kind is dropped and stale_cnt increments, saturating at 16'hFFFF; multiple drops in one cycle count individually.
REQ-033 Undefined: every update in RUN is captured unconditionally; stale_cnt tied to 0.

Verification
REQ-034 HASH=32'h4ACA_1E16, present 32'h4ACA_1E16 -> ready=1 after 1 cycle; present 32'h1 instead -> hash_err=1, ready stays 0 until rst.
REQ-035 RUN, ch0 combo 32'hA5 tag 5 at t, seq 32'h5A tag 6 at t+1 -> out_data[0]=32'hA5 src 0 at t+2, 32'h5A src 1 at t+4.
REQ-036 SEQ_W=16, combo tag 16'hFFFE, then seq tag 16'h0001 -> seq selected (wrap-around newer).
REQ-037 Same-cycle combo tag 9 and seq tag 9 on ch2 -> out_src[2]=0, out_data[2]=combo value.
REQ-038 Filter enabled: combo tag 10 then combo tag 7 on ch1 -> second dropped, out unchanged, stale_cnt=1; filter disabled -> tag-7 value appears, stale_cnt=0.
REQ-039 Assert rst one cycle after a seq strobe -> all outputs 0, WAIT_HASH, strobed value never appears.
